// File: rtl/channel_frame_ctrl.sv
// rtl/channel_frame_ctrl.sv - frame sequencer that passes a bit stream through a Gilbert channel model
module channel_frame_ctrl #(
    parameter int FRAME_W = 16,
    parameter int PE_GOOD = 1,
    parameter int PE_BAD  = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [FRAME_W-1:0] frame_len,
    input  logic               chan_good,
    output logic               chan_step,
    input  logic               in_valid,
    input  logic               in_bit,
    output logic               in_ready,
    output logic               out_valid,
    output logic               out_bit,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic [FRAME_W-1:0] err_cnt,
    output logic [FRAME_W-1:0] bad_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [9:0]         LFSR_SEED = 10'h001;
    localparam logic [FRAME_W-1:0] CNT_ONE   = {{(FRAME_W-1){1'b0}}, 1'b1};

    // Thresholds are 11 bits wide so that 1024 (always flip) is representable
    // against the 10-bit LFSR value.
    localparam logic [10:0] THR_GOOD = 11'(PE_GOOD);
    localparam logic [10:0] THR_BAD  = 11'(PE_BAD);

    logic [1:0]         state_q,     state_d;
    logic [9:0]         lfsr_q,      lfsr_d;
    logic [FRAME_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic [FRAME_W-1:0] len_q,       len_d;
    logic [FRAME_W-1:0] err_cnt_q,   err_cnt_d;
    logic [FRAME_W-1:0] bad_cnt_q,   bad_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               out_bit_q,   out_bit_d;

    logic        abort_hit;
    logic        start_hit;
    logic        in_ready_c;
    logic        xfer;
    logic        out_hs;
    logic        last_bit;
    logic [10:0] thr;
    logic        flip;

    // Handshake and flip decision for the current cycle.
    always_comb begin
        // Abort only matters once a frame is underway; in IDLE it is a no-op.
        abort_hit  = abort && (state_q != ST_IDLE);
        // Abort wins over start; a zero-length frame is never started.
        start_hit  = (state_q == ST_IDLE) && start && !abort && (frame_len != '0);
        // Single output register: accept a new bit when it is empty or draining now.
        in_ready_c = (state_q == ST_RUN) && (!out_valid_q || out_ready);
        xfer       = in_valid && in_ready_c;
        out_hs     = out_valid_q && out_ready;
        last_bit   = (bit_cnt_q == (len_q - CNT_ONE));
        thr        = chan_good ? THR_GOOD : THR_BAD;
        flip       = ({1'b0, lfsr_q} < thr);
    end

    // Frame sequencing: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_hit) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer && last_bit) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_hit) begin
            state_d = ST_IDLE;
        end
    end

    // Per-frame counters and the error LFSR; statistics hold after the frame.
    always_comb begin
        lfsr_d    = lfsr_q;
        bit_cnt_d = bit_cnt_q;
        len_d     = len_q;
        err_cnt_d = err_cnt_q;
        bad_cnt_d = bad_cnt_q;
        if (start_hit) begin
            // Reseeding makes the flip pattern repeatable frame to frame.
            lfsr_d    = LFSR_SEED;
            bit_cnt_d = '0;
            len_d     = frame_len;
            err_cnt_d = '0;
            bad_cnt_d = '0;
        end else if (xfer && !abort_hit) begin
            lfsr_d    = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[2]};
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            err_cnt_d = err_cnt_q + FRAME_W'(flip);
            bad_cnt_d = bad_cnt_q + FRAME_W'(!chan_good);
        end
    end

    // Output register: load on transfer, clear on handshake, drop on abort.
    always_comb begin
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        if (abort_hit) begin
            out_valid_d = 1'b0;
        end else if (xfer) begin
            out_valid_d = 1'b1;
            out_bit_d   = in_bit ^ flip;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= LFSR_SEED;
            bit_cnt_q   <= '0;
            len_q       <= '0;
            err_cnt_q   <= '0;
            bad_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            bit_cnt_q   <= bit_cnt_d;
            len_q       <= len_d;
            err_cnt_q   <= err_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
        end
    end

    // The channel model advances exactly once per accepted input bit.
    assign chan_step = xfer;
    assign in_ready  = in_ready_c;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE) && !abort;
    assign err_cnt   = err_cnt_q;
    assign bad_cnt   = bad_cnt_q;

endmodule
